nn_sigmoid_scheduler: RTL and testbench
=======================================

Name: nn_sigmoid_scheduler

Overview:
Sequencer that time-shares a single sequential sigmoid_approx unit across the three neuron activations of the 2-2-1 network: h1, then h2, then the output neuron. It sits between the combinational layer datapath (matrix multiplies plus bias adders) and one sigmoid instance. It replaces the per-neuron sigmoid instances and the ad-hoc out_valid counter with an explicit FSM that adds watchdog and abort handling. It holds the hidden activations that feed the layer-2 datapath and registers the final result.

Parameters:
exp_width, 8, float exponent width
mant_width, 24, float mantissa width incl. hidden bit; word width W = exp_width+mant_width
TIMEOUT, 255, max cycles to wait for sig_out_valid after an issue before abort
CNT_W, 8, width of watchdog and latency counters; TIMEOUT must be < 2^CNT_W

Ports:
clk  in  1  clock
rst_l  in  1  reset, synchronous, active-low
start  in  1  request one inference; sampled only in IDLE
abort  in  1  synchronous cancel of the current inference
h1_pre  in  W  layer-1 neuron-1 pre-activation (combinational from datapath)
h2_pre  in  W  layer-1 neuron-2 pre-activation
out_pre  in  W  layer-2 pre-activation; combinational from h1_act/h2_act/w31/w32/b3
sig_in_x  out  W  operand to the shared sigmoid; registered, held stable during a wait
sig_in_valid  out  1  one-cycle issue pulse to the sigmoid
sig_out  in  W  sigmoid result
sig_out_valid  in  1  sigmoid completion pulse
h1_act  out  W  registered sigmoid(h1_pre)
h2_act  out  W  registered sigmoid(h2_pre)
result  out  W  registered network output
done  out  1  one-cycle pulse when result is updated
busy  out  1  high in every state except IDLE
timeout  out  1  one-cycle pulse on watchdog expiry
last_latency  out  CNT_W  cycles from start acceptance to done, saturating

Behaviour:
- Reset (rst_l=0 at posedge): state IDLE; all outputs 0, including W-wide registers, done, timeout, sig_in_valid and last_latency. Watchdog and latency counters are 0.
- States: IDLE, WAIT_H1, WAIT_H2, ISSUE_OUT, WAIT_OUT.
- IDLE with start=1 and abort=0: sig_in_x<=h1_pre; sig_in_valid<=1; go to WAIT_H1; lat counter<=1. Issue pulse is visible the cycle after start.
- WAIT_H1 with sig_out_valid: h1_act<=sig_out; sig_in_x<=h2_pre; sig_in_valid<=1; go to WAIT_H2.
- WAIT_H2 with sig_out_valid: h2_act<=sig_out; go to ISSUE_OUT. ISSUE_OUT lasts one cycle so out_pre settles on the new h1_act/h2_act.
- ISSUE_OUT: sig_in_x<=out_pre; sig_in_valid<=1; go to WAIT_OUT.
- WAIT_OUT with sig_out_valid: result<=sig_out; done<=1; last_latency<=lat counter (saturated); go to IDLE.
- sig_in_valid is high exactly one cycle per issue, three issues per inference. sig_in_x changes only on an issue.
- sig_out_valid is ignored in IDLE and ISSUE_OUT; it is counted at most once per WAIT state.
- start while busy: ignored, not queued.
- start and sig_out_valid in IDLE in the same cycle: start is accepted and the stray valid is ignored.
- Watchdog:
  - cleared on every issue; increments each cycle in a WAIT state without sig_out_valid.
  - when it reaches TIMEOUT: timeout<=1, go to IDLE.
  - h1_act, h2_act and result hold their values; done is not asserted.
- abort=1 in any non-IDLE state: go to IDLE next cycle; sig_in_valid<=0; no done or timeout pulse; registers hold.
  - abort in IDLE: no effect.
  - abort has priority over sig_out_valid, watchdog expiry and start.
- Latency counter: increments each busy cycle and saturates at 2^CNT_W-1.
- Minimum inference latency with sigmoid latency L: start to done = 3L+4 cycles.
- Reset mid-operation: immediate return to reset values at the next edge. A sigmoid result arriving later is ignored because the FSM is in IDLE.

Decomposition:
- Shared package nn_pkg: FSM state enum; float word width localparam; watchdog/latency counter width.
- One natural sub-module, nn_watchdog: load/clear, count, expire flag. Everything else stays flat.

Test Plan:
- Sigmoid model L=17, h1_pre=0x00000000 (sigmoid(0)→0x3F000000), similarly h2, out_pre=0x3F800000 → result=model value, done one pulse at cycle 3·17+4=55, last_latency=55, three sig_in_valid pulses.
- Model withholds sig_out_valid on the second issue, TIMEOUT=255 → timeout pulse 255 cycles after the h2 issue, busy drops, h1_act updated, h2_act/result unchanged, no done.
- abort asserted in WAIT_H2 coincident with sig_out_valid → IDLE next cycle, h2_act unchanged, no done; a subsequent start completes normally.
- start pulsed repeatedly during an inference → exactly one done, three issues; a start in the cycle of done's IDLE return is accepted one cycle later.
- rst_l low for one cycle in WAIT_OUT → all outputs 0 next cycle; a late sig_out_valid does not update result or assert done.
- Model latency 300 with CNT_W=8, TIMEOUT=255 → timeout on the first issue.

Source files
------------

// File: rtl/nn_pkg.sv
// ============================================================================
// Module   : nn_pkg
// Purpose  : Shared definitions for the 2-2-1 network sigmoid sequencer:
//            float word geometry, watchdog/latency counter width and the
//            scheduler state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_pkg;

    localparam int C_EXP_WIDTH  = 8;
    localparam int C_MANT_WIDTH = 24;   // includes the hidden bit
    localparam int C_WORD_W     = C_EXP_WIDTH + C_MANT_WIDTH;
    localparam int C_CNT_W      = 8;

    // One state per sigmoid wait, plus a settle state before the output
    // neuron so its pre-activation reflects the freshly stored hidden values.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_H1   = 3'd1,
        ST_WAIT_H2   = 3'd2,
        ST_ISSUE_OUT = 3'd3,
        ST_WAIT_OUT  = 3'd4
    } nn_state_t;

endpackage : nn_pkg

`default_nettype wire

// File: rtl/nn_watchdog.sv
// ============================================================================
// Module   : nn_watchdog
// Purpose  : Cycle counter guarding one outstanding sigmoid request.
//            Counts while enabled, holds at the limit, and flags expiry in
//            the cycle it would reach TIMEOUT.
// Ports    : clk, rst_l  - clock, synchronous active-low reset
//            clear       - force the count to zero (wins over enable)
//            enable      - count this cycle
//            expire      - count has reached TIMEOUT-1 while enabled
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_watchdog
    import nn_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = C_CNT_W
) (
    input  logic clk,
    input  logic rst_l,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // Expiry fires on the edge that would take the count to TIMEOUT, so the
    // timeout pulse lands exactly TIMEOUT cycles after the issue pulse.
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count >= C_LIMIT);
    assign expire     = enable && w_at_limit;

    always_ff @(posedge clk) begin
        if (!rst_l || clear) begin
            r_count <= '0;
        end else if (enable && !w_at_limit) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule : nn_watchdog

`default_nettype wire

// File: rtl/nn_sigmoid_scheduler.sv
// ============================================================================
// Module   : nn_sigmoid_scheduler
// Purpose  : Time-shares one sequential sigmoid unit across the three neuron
//            activations of the 2-2-1 network (h1, h2, output), with a
//            watchdog on every outstanding request and synchronous abort.
// Ports    : clk, rst_l          - clock, synchronous active-low reset
//            start, abort        - request / cancel an inference
//            h1_pre, h2_pre      - layer-1 pre-activations
//            out_pre             - layer-2 pre-activation (from h1/h2_act)
//            sig_in_x/_valid     - operand and issue pulse to the sigmoid
//            sig_out/_valid      - sigmoid result and completion pulse
//            h1_act, h2_act      - stored hidden activations
//            result, done        - network output and its update pulse
//            busy, timeout       - status, watchdog expiry pulse
//            last_latency        - start-to-done cycles, saturating
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_sigmoid_scheduler
    import nn_pkg::*;
#(
    parameter int EXP_WIDTH  = C_EXP_WIDTH,
    parameter int MANT_WIDTH = C_MANT_WIDTH,
    parameter int TIMEOUT    = 255,          // must be below 2**CNT_W
    parameter int CNT_W      = C_CNT_W,
    localparam int W         = EXP_WIDTH + MANT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     h1_pre,
    input  logic [W-1:0]     h2_pre,
    input  logic [W-1:0]     out_pre,
    output logic [W-1:0]     sig_in_x,
    output logic             sig_in_valid,
    input  logic [W-1:0]     sig_out,
    input  logic             sig_out_valid,
    output logic [W-1:0]     h1_act,
    output logic [W-1:0]     h2_act,
    output logic [W-1:0]     result,
    output logic             done,
    output logic             busy,
    output logic             timeout,
    output logic [CNT_W-1:0] last_latency
);

    localparam logic [CNT_W-1:0] C_LAT_MAX = {CNT_W{1'b1}};

    nn_state_t        r_state;
    logic [W-1:0]     r_sig_in_x;
    logic             r_sig_in_valid;
    logic [W-1:0]     r_h1_act;
    logic [W-1:0]     r_h2_act;
    logic [W-1:0]     r_result;
    logic             r_done;
    logic             r_timeout;
    logic [CNT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_last_latency;

    logic             w_in_wait;
    logic             w_wd_enable;
    logic             w_wd_clear;
    logic             w_wd_expire;

    assign w_in_wait = (r_state == ST_WAIT_H1) ||
                       (r_state == ST_WAIT_H2) ||
                       (r_state == ST_WAIT_OUT);

    // The watchdog only runs while a request is genuinely outstanding. Any
    // other cycle (idle, settle, result arrival, abort) restarts it, which
    // also covers every issue since each issue follows one of those cycles.
    assign w_wd_enable = w_in_wait && !sig_out_valid && !abort;
    assign w_wd_clear  = !w_wd_enable;

    nn_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_l   (rst_l),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expire  (w_wd_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state        <= ST_IDLE;
            r_sig_in_x     <= '0;
            r_sig_in_valid <= 1'b0;
            r_h1_act       <= '0;
            r_h2_act       <= '0;
            r_result       <= '0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_lat          <= '0;
            r_last_latency <= '0;
        end else begin
            // Pulses default low; only the branches below raise them.
            r_sig_in_valid <= 1'b0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;

            if ((r_state != ST_IDLE) && (r_lat != C_LAT_MAX)) begin
                r_lat <= r_lat + CNT_W'(1);
            end

            if ((r_state != ST_IDLE) && abort) begin
                // Abort outranks result arrival, expiry and start; stored
                // activations and result are left untouched.
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // A coincident stray sig_out_valid is not looked at.
                        if (start && !abort) begin
                            r_sig_in_x     <= h1_pre;
                            r_sig_in_valid <= 1'b1;
                            r_lat          <= CNT_W'(1);
                            r_state        <= ST_WAIT_H1;
                        end
                    end

                    ST_WAIT_H1: begin
                        if (sig_out_valid) begin
                            r_h1_act       <= sig_out;
                            r_sig_in_x     <= h2_pre;
                            r_sig_in_valid <= 1'b1;
                            r_state        <= ST_WAIT_H2;
                        end else if (w_wd_expire) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end

                    ST_WAIT_H2: begin
                        if (sig_out_valid) begin
                            r_h2_act <= sig_out;
                            r_state  <= ST_ISSUE_OUT;
                        end else if (w_wd_expire) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end

                    ST_ISSUE_OUT: begin
                        // out_pre is now derived from the updated h1/h2_act.
                        r_sig_in_x     <= out_pre;
                        r_sig_in_valid <= 1'b1;
                        r_state        <= ST_WAIT_OUT;
                    end

                    ST_WAIT_OUT: begin
                        if (sig_out_valid) begin
                            r_result       <= sig_out;
                            r_done         <= 1'b1;
                            r_last_latency <= r_lat;
                            r_state        <= ST_IDLE;
                        end else if (w_wd_expire) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sig_in_x     = r_sig_in_x;
    assign sig_in_valid = r_sig_in_valid;
    assign h1_act       = r_h1_act;
    assign h2_act       = r_h2_act;
    assign result       = r_result;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign last_latency = r_last_latency;
    assign busy         = (r_state != ST_IDLE);

endmodule : nn_sigmoid_scheduler

`default_nettype wire

// File: tb/tb_nn_sigmoid_scheduler.sv
// ============================================================================
// Module   : tb_nn_sigmoid_scheduler
// Purpose  : Directed self-checking bench for nn_sigmoid_scheduler with a
//            behavioural sequential sigmoid of configurable latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_sigmoid_scheduler;

    logic        clk   = 1'b0;
    logic        rst_l = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] h1_pre = '0;
    logic [31:0] h2_pre = '0;
    logic [31:0] out_pre;
    logic [31:0] sig_in_x;
    logic        sig_in_valid;
    logic [31:0] sig_out;
    logic        sig_out_valid;
    logic [31:0] h1_act;
    logic [31:0] h2_act;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        timeout;
    logic [7:0]  last_latency;

    // Sigmoid model state and injected stray valid
    logic        m_valid   = 1'b0;
    logic [31:0] m_data    = '0;
    logic [31:0] m_op      = '0;
    int          m_cnt     = 0;
    int          lat_cfg   = 17;
    int          drop_issue = -1;
    logic        inj_valid = 1'b0;
    logic [31:0] inj_data  = '0;

    int          n_issue = 0;
    int          n_done  = 0;
    int          n_to    = 0;
    logic [31:0] op_log [64];

    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Layer-2 pre-activation stand-in: depends on h2_act so a premature
    // sample of out_pre yields a different operand.
    assign out_pre       = (h2_act == 32'h3F000000) ? 32'h3F800000 : 32'hDEADBEEF;
    assign sig_out_valid = m_valid | inj_valid;
    assign sig_out       = inj_valid ? inj_data : m_data;

    nn_sigmoid_scheduler #(
        .EXP_WIDTH    (8),
        .MANT_WIDTH   (24),
        .TIMEOUT      (255),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .start        (start),
        .abort        (abort),
        .h1_pre       (h1_pre),
        .h2_pre       (h2_pre),
        .out_pre      (out_pre),
        .sig_in_x     (sig_in_x),
        .sig_in_valid (sig_in_valid),
        .sig_out      (sig_out),
        .sig_out_valid(sig_out_valid),
        .h1_act       (h1_act),
        .h2_act       (h2_act),
        .result       (result),
        .done         (done),
        .busy         (busy),
        .timeout      (timeout),
        .last_latency (last_latency)
    );

    // sigmoid(0)=0.5, sigmoid(1)=0.7311, sigmoid(-1)=0.2689; other inputs
    // get an arbitrary but recognisable mapping.
    function automatic logic [31:0] sig_fn(input logic [31:0] x);
        case (x)
            32'h00000000: return 32'h3F000000;
            32'h3F800000: return 32'h3F3B26A8;
            32'hBF800000: return 32'h3E89B2B0;
            default:      return x ^ 32'hFFFF0000;
        endcase
    endfunction

    // Result becomes visible lat_cfg cycles after the issue pulse is visible.
    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_data  <= sig_fn(m_op);
            end
            m_cnt <= m_cnt - 1;
        end
        if (sig_in_valid) begin
            op_log[n_issue % 64] <= sig_in_x;
            if (n_issue != drop_issue) begin
                m_op  <= sig_in_x;
                m_cnt <= lat_cfg - 1;
            end
            n_issue <= n_issue + 1;
        end
        if (done)    n_done <= n_done + 1;
        if (timeout) n_to   <= n_to + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise start at a negedge; k is the number of edges since acceptance
    // when the awaited pulse is seen (or the bound when it never comes).
    task automatic launch(input bit hold, input bit want_to, input int max_cyc, output int k);
        start = 1'b1;
        k     = -1;
        do begin
            @(negedge clk);
            k++;
            if (!hold) start = 1'b0;
            inj_valid = 1'b0;
        end while (!(want_to ? timeout : done) && k < max_cyc);
    endtask

    int k;
    int b_iss, b_done, b_to;

    initial begin
        // ---------------- reset ----------------
        tick(3);
        check_eq("rst_sig_in_x", sig_in_x, 32'h0);
        check_eq("rst_h1_act", h1_act, 32'h0);
        check_eq("rst_h2_act", h2_act, 32'h0);
        check_eq("rst_result", result, 32'h0);
        check_eq("rst_pulses", {28'h0, done, timeout, sig_in_valid, busy}, 32'h0);
        check_eq("rst_last_latency", {24'h0, last_latency}, 32'h0);
        rst_l = 1'b1;
        tick(2);

        // ---------------- normal inference, stray valid with start ----------
        h1_pre = 32'hBF800000;
        h2_pre = 32'h00000000;
        b_iss = n_issue; b_done = n_done;
        inj_valid = 1'b1;
        inj_data  = 32'h12345678;
        launch(1'b0, 1'b0, 200, k);
        check_eq("t1_latency_cycles", k, 55);
        check_eq("t1_last_latency", {24'h0, last_latency}, 32'd55);
        check_eq("t1_result", result, 32'h3F3B26A8);
        check_eq("t1_h1_act", h1_act, 32'h3E89B2B0);
        check_eq("t1_h2_act", h2_act, 32'h3F000000);
        check_eq("t1_busy_at_done", {31'h0, busy}, 32'h0);
        tick(3);
        check_eq("t1_issues", n_issue - b_iss, 3);
        check_eq("t1_dones", n_done - b_done, 1);
        check_eq("t1_op0", op_log[b_iss % 64], 32'hBF800000);
        check_eq("t1_op1", op_log[(b_iss + 1) % 64], 32'h00000000);
        check_eq("t1_op2", op_log[(b_iss + 2) % 64], 32'h3F800000);
        tick(20);

        // ---------------- start held high throughout ----------------
        h1_pre = 32'h00000000;
        h2_pre = 32'h00000000;
        b_iss = n_issue; b_done = n_done;
        launch(1'b1, 1'b0, 200, k);
        check_eq("t2_latency_cycles", k, 55);
        check_eq("t2_result", result, 32'h3F3B26A8);
        @(negedge clk);
        check_eq("t2_restart_issue", {31'h0, sig_in_valid}, 32'h1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t2_abort_idle", {31'h0, busy}, 32'h0);
        tick(25);
        check_eq("t2_issues", n_issue - b_iss, 4);
        check_eq("t2_dones", n_done - b_done, 1);

        // ---------------- abort coincident with h2 result ----------------
        h1_pre = 32'h3F800000;
        h2_pre = 32'hBF800000;
        b_iss = n_issue; b_done = n_done; b_to = n_to;
        start = 1'b1;
        k = -1;
        do begin
            @(negedge clk);
            k++;
            start = 1'b0;
        end while (!(sig_out_valid && (n_issue == b_iss + 2)) && k < 100);
        check_eq("t3_h2_valid_cycle", k, 35);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t3_abort_idle", {31'h0, busy}, 32'h0);
        check_eq("t3_h1_act", h1_act, 32'h3F3B26A8);
        check_eq("t3_h2_act_held", h2_act, 32'h3F000000);
        tick(5);
        check_eq("t3_no_done", n_done - b_done, 0);
        check_eq("t3_no_timeout", n_to - b_to, 0);
        launch(1'b0, 1'b0, 200, k);
        check_eq("t3_rerun_cycles", k, 55);
        check_eq("t3_rerun_h2_act", h2_act, 32'h3E89B2B0);
        check_eq("t3_rerun_result", result, 32'h2152BEEF);
        tick(25);

        // ---------------- watchdog on second issue ----------------
        h1_pre = 32'h00000000;
        h2_pre = 32'h3F800000;
        b_iss = n_issue; b_done = n_done; b_to = n_to;
        drop_issue = n_issue + 1;
        launch(1'b0, 1'b1, 400, k);
        check_eq("t4_timeout_cycle", k, 273);
        @(negedge clk);
        check_eq("t4_busy", {31'h0, busy}, 32'h0);
        check_eq("t4_h1_act", h1_act, 32'h3F000000);
        check_eq("t4_h2_act_held", h2_act, 32'h3E89B2B0);
        check_eq("t4_result_held", result, 32'h2152BEEF);
        check_eq("t4_no_done", n_done - b_done, 0);
        check_eq("t4_timeouts", n_to - b_to, 1);
        check_eq("t4_issues", n_issue - b_iss, 2);
        drop_issue = -1;
        tick(5);

        // ---------------- reset during WAIT_OUT ----------------
        h1_pre = 32'h00000000;
        h2_pre = 32'h00000000;
        b_iss = n_issue; b_done = n_done;
        start = 1'b1;
        k = -1;
        do begin
            @(negedge clk);
            k++;
            start = 1'b0;
        end while ((n_issue != b_iss + 3) && k < 100);
        check_eq("t5_third_issue_cycle", k, 38);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        check_eq("t5_sig_in_x", sig_in_x, 32'h0);
        check_eq("t5_h1_act", h1_act, 32'h0);
        check_eq("t5_h2_act", h2_act, 32'h0);
        check_eq("t5_result", result, 32'h0);
        check_eq("t5_status", {23'h0, last_latency, busy}, 32'h0);
        tick(40);
        check_eq("t5_late_result", result, 32'h0);
        check_eq("t5_no_done", n_done - b_done, 0);
        check_eq("t5_idle", {31'h0, busy}, 32'h0);

        // ---------------- sigmoid slower than the watchdog ----------------
        lat_cfg = 300;
        h1_pre  = 32'h00000000;
        b_iss = n_issue; b_done = n_done;
        launch(1'b0, 1'b1, 400, k);
        check_eq("t6_timeout_cycle", k, 255);
        check_eq("t6_h1_act_held", h1_act, 32'h0);
        tick(60);
        check_eq("t6_late_h1_act", h1_act, 32'h0);
        check_eq("t6_idle", {31'h0, busy}, 32'h0);
        check_eq("t6_issues", n_issue - b_iss, 1);
        check_eq("t6_no_done", n_done - b_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_nn_sigmoid_scheduler

`default_nettype wire
